// File: rtl/bcd_pkg.sv
// Shared constants and phase encoding for the double-dabble binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGITS = 3;
    localparam int NIBBLE_W   = 4;
    localparam int BCD_W      = BCD_DIGITS * NIBBLE_W;

    typedef enum logic [1:0] {
        PH_LOAD  = 2'd0,
        PH_SHIFT = 2'd1,
        PH_DONE  = 2'd2
    } phase_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the shift.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [NIBBLE_W-1:0] nibble_o
);

    always_comb begin
        if (nibble_i >= NIBBLE_W'(5)) begin
            nibble_o = nibble_i + NIBBLE_W'(3);
        end else begin
            nibble_o = nibble_i;
        end
    end

endmodule

// File: rtl/binary_to_bcd.sv
// Free-running sequential binary-to-BCD converter: LOAD, WIDTH shift cycles, DONE,
// repeating every WIDTH+2 cycles with registered hundreds/tens/ones digits.
module binary_to_bcd
    import bcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] binary_in,
    output logic [3:0]       O,
    output logic [3:0]       T,
    output logic [3:0]       H
);

    localparam int              CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH + 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BCD_W-1:0]    bcd_adj;
    logic [NIBBLE_W-1:0] h_q, h_d;
    logic [NIBBLE_W-1:0] t_q, t_d;
    logic [NIBBLE_W-1:0] o_q, o_d;
    phase_e              phase;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .nibble_i (bcd_q[gi*NIBBLE_W +: NIBBLE_W]),
                .nibble_o (bcd_adj[gi*NIBBLE_W +: NIBBLE_W])
            );
        end
    endgenerate

    always_comb begin
        phase = PH_SHIFT;
        if (cnt_q == '0) begin
            phase = PH_LOAD;
        end else if (cnt_q == CNT_DONE) begin
            phase = PH_DONE;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        bin_d = bin_q;
        bcd_d = bcd_q;
        h_d   = h_q;
        t_d   = t_q;
        o_d   = o_q;
        case (phase)
            PH_LOAD: begin
                bin_d = binary_in;
                bcd_d = '0;
            end
            PH_SHIFT: begin
                // Corrected digits shift up; the bit falling off the hundreds nibble is always 0.
                bcd_d = BCD_W'({bcd_adj, bin_q[WIDTH-1]});
                bin_d = bin_q << 1;
            end
            PH_DONE: begin
                h_d   = bcd_q[2*NIBBLE_W +: NIBBLE_W];
                t_d   = bcd_q[1*NIBBLE_W +: NIBBLE_W];
                o_d   = bcd_q[0*NIBBLE_W +: NIBBLE_W];
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            bin_q <= '0;
            bcd_q <= '0;
            h_q   <= '0;
            t_q   <= '0;
            o_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            h_q   <= h_d;
            t_q   <= t_d;
            o_q   <= o_d;
        end
    end

    assign H = h_q;
    assign T = t_q;
    assign O = o_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench: stimulus pushes expected digits at each LOAD, the monitor pops at each DONE
// edge and checks the digits hold steady on every other cycle.
module tb_binary_to_bcd;

    logic       clk;
    logic       reset_n;
    logic [7:0] binary_in;
    logic [3:0] O, T, H;

    int checks   = 0;
    int failures = 0;
    int cyc;
    logic [11:0] exp_q[$];
    logic [11:0] last_exp = 12'h000;

    binary_to_bcd #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .binary_in (binary_in),
        .O         (O),
        .T         (T),
        .H         (H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since reset release; edge 1 is LOAD, edges 10, 20, ... are DONE.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic compare(input string name, input logic [11:0] exp);
        checks++;
        if ({H, T, O} !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got H=%0d T=%0d O=%0d, expected H=%0d T=%0d O=%0d",
                     name, cyc, H, T, O, exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            last_exp = 12'h000;
            compare("reset", 12'h000);
        end else if (cyc != 0 && cyc % 10 == 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done cyc=%0d: DONE edge with no expected entry queued", cyc);
            end else begin
                last_exp = exp_q.pop_front();
                compare("done", last_exp);
                $display("done cyc=%0d H=%0d T=%0d O=%0d", cyc, H, T, O);
            end
        end else begin
            compare("hold", last_exp);
        end
    end

    task automatic issue(input logic [7:0] v, input int h, input int t, input int o);
        while (cyc % 10 != 0) @(negedge clk);
        binary_in = v;
        exp_q.push_back({4'(h), 4'(t), 4'(o)});
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        binary_in = 8'd200;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        issue(8'd200, 2, 0, 0);

        issue(8'd0,   0, 0, 0); issue(8'd0,   0, 0, 0);
        issue(8'd9,   0, 0, 9); issue(8'd9,   0, 0, 9);
        issue(8'd10,  0, 1, 0); issue(8'd10,  0, 1, 0);
        issue(8'd99,  0, 9, 9); issue(8'd99,  0, 9, 9);
        issue(8'd100, 1, 0, 0); issue(8'd100, 1, 0, 0);
        issue(8'd128, 1, 2, 8); issue(8'd128, 1, 2, 8);
        issue(8'd255, 2, 5, 5); issue(8'd255, 2, 5, 5);

        issue(8'd37, 0, 3, 7);
        while (cyc % 10 != 4) @(negedge clk);
        binary_in = 8'd142;
        issue(8'd142, 1, 4, 2);

        issue(8'd255, 2, 5, 5);
        issue(8'd255, 2, 5, 5);
        while (cyc % 10 != 5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        compare("async_reset", 12'h000);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        issue(8'd255, 2, 5, 5);

        for (int v = 0; v < 256; v++) begin
            issue(8'(v), v / 100, (v / 10) % 10, v % 10);
        end

        repeat (12) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
